mem_sync_rw: RTL and testbench
==============================

// Module: mem_sync_rw
// PURPOSE
//  Parametrised single-port synchronous RAM with a valid/ready request port and a pipelined read-response port.
//  Adds over the older tri-state memory:
//  - separate write and read data buses
//  - per-byte write enables
//  - configurable read latency
//  - self-clearing after reset
//  Sits between a bus master (CPU/DMA datapath) and local storage.
// PARAMETERS
//  AWIDTH  5  address bits; depth = 2**AWIDTH words
//  DWIDTH  32 word width; must be a multiple of 8 (NBYTES = DWIDTH/8)
//  RD_LAT  1  read latency in cycles from request accept to rsp_valid; legal 1..3
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  req_valid    in   1        request present
//  req_ready    out  1        block can accept a request (READY state only)
//  req_wr       in   1        1 = write, 0 = read
//  req_addr     in   AWIDTH   word address
//  req_wdata    in   DWIDTH   write data
//  req_be       in   NBYTES   byte enables; bit i gates byte i
//  perr_inject  in   1        test hook: invert stored parity of written bytes
//  rsp_valid    out  1        read data valid (1-cycle pulse per read)
//  rsp_rdata    out  DWIDTH   read data
//  rsp_perr     out  1        parity error on this response
//  init_done    out  1        memory clear complete
// BEHAVIOUR
//  - Reset (async assert, sync release): state=CLEAR, clr_addr=0, read pipe flushed.
//    Outputs go low: req_ready, rsp_valid, rsp_rdata, rsp_perr, init_done.
//  - CLEAR: one word per cycle.
//    - Writes 0 to mem[clr_addr], then clr_addr++.
//    - When clr_addr = 2**AWIDTH-1 is written -> READY.
//    - Takes exactly 2**AWIDTH cycles; req_ready=0 throughout.
//  - READY: req_ready=1 and init_done=1, both held until the next reset.
//    - A request is accepted on the edge where req_valid & req_ready.
//  - Write accept: same edge, mem[addr][8i+7:8i] <= wdata byte i for every be[i]=1.
//    - be=0 is a legal no-op.
//    - No response is generated for writes.
//  - Read accept: addr sampled at the accept edge.
//    - rsp_valid=1 for exactly one cycle, RD_LAT cycles later; rsp_rdata valid in that cycle.
//    - Reads are fully pipelined: one per cycle, responses in request order.
//    - No response backpressure.
//  - rsp_rdata holds its last value when rsp_valid=0; it resets to 0.
//  - Read following a write to the same address on the next edge returns the new data.
//    - The write commits before the read samples the array.
//  - req_wdata/req_be are don't-care on reads; req_wr/req_addr are don't-care when req_valid=0.
//  - Reset mid-operation:
//    - In-flight reads are dropped and no rsp_valid is produced.
//    - The array is cleared again.
// CONFIGURATION
//  MEM_PARITY_EN defined:
//   - One even-parity bit is stored per byte on every write, and by CLEAR.
//   - On read, parity is recomputed; rsp_perr = OR of byte mismatches, aligned with rsp_valid.
//   - perr_inject=1 on a write stores inverted parity for the enabled bytes.
//  MEM_PARITY_EN undefined:
//   - No parity storage; perr_inject is ignored; rsp_perr is tied 0.
//   - The port list is identical in both builds.
// STRUCTURE
//  Package mem_pkg:
//   - state_t enum {CLEAR, READY}
//   - RD_LAT_MAX=3
//   - function byte_parity(input [7:0])
//  Sub-module mem_rd_pipe:
//   - RD_LAT-deep valid/data(/perr) shift register, flushed by rst_n.
//   - The array read is the first stage.
// TESTING (AWIDTH=5, DWIDTH=32)
//  1. Release reset, hold req_valid=1 -> req_ready=0 for 32 cycles, then 1; init_done=1; read of every address returns 0x00000000.
//  2. Write addr 3 = 0xDEADBEEF (be=4'hF), then write addr 3 = 0x11223344 with be=4'b0101; read addr 3
//     -> rsp_rdata=0xDE22BE44, RD_LAT cycles after accept.
//  3. RD_LAT=3: reads of addrs 0,1,2 on consecutive cycles (preloaded 0xA0,0xA1,0xA2)
//     -> rsp_valid high 3 consecutive cycles starting 3 cycles after first accept, data in order.
//  4. Write addr 7 = 0x5 then read addr 7 on the next cycle -> 0x5; write with be=0 to addr 7 -> subsequent read still 0x5.
//  5. Issue a read, assert rst_n=0 before the response -> no rsp_valid appears.
//     After release: 32-cycle CLEAR, then addr 7 reads 0.
//  6. MEM_PARITY_EN: write addr 9 = 0xFF with perr_inject=1, be=4'b0001 -> read gives rsp_perr=1; rewrite with inject=0 -> rsp_perr=0.
//     Undefined: rsp_perr=0 always.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, limits and parity helper for the sync RAM
//
// Contents:
//   state_t      controller state (CLEAR while zeroing the array, READY after)
//   RD_LAT_MAX   deepest supported read pipeline
//   byte_parity  even-parity bit for one byte
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int RD_LAT_MAX = 3;

  // Even parity: the stored bit makes the 9-bit total have an even number of ones.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - read-response shift register (valid/data/perr)
//
// The caller presents the combinational array read on in_*; stage 0 captures it
// on the accept edge, so a read emerges RD_LAT edges later counting that edge.
// Data stages only load when valid moves into them, so out_data holds the last
// response between pulses. rst_n flushes every stage asynchronously.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              read accepted this edge
//   in_data, in_perr      array word and its parity-mismatch flag
//   out_valid             one-cycle response pulse
//   out_data              response word (held while out_valid=0)
//   out_perr              parity error, only asserted with out_valid
module mem_rd_pipe #(
  parameter int DWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_perr,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_perr
);

  logic [RD_LAT-1:0] valid_q, valid_d;
  logic [RD_LAT-1:0] perr_q, perr_d;
  logic [DWIDTH-1:0] data_q [RD_LAT];
  logic [DWIDTH-1:0] data_d [RD_LAT];

  always_comb begin
    valid_d = valid_q;
    perr_d  = perr_q;
    data_d  = data_q;

    valid_d[0] = in_valid;
    if (in_valid) begin
      data_d[0] = in_data;
      perr_d[0] = in_perr;
    end

    for (int i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) begin
        data_d[i] = data_q[i-1];
        perr_d[i] = perr_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      perr_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[RD_LAT-1];
  assign out_data  = data_q[RD_LAT-1];
  assign out_perr  = valid_q[RD_LAT-1] & perr_q[RD_LAT-1];

endmodule

// File: rtl/mem_sync_rw.sv
// rtl/mem_sync_rw.sv - single-port sync RAM, valid/ready requests, pipelined reads
//
// Optional feature macro: MEM_PARITY_EN (per-byte even parity with rsp_perr).
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      request present
//   req_ready      high in READY state only
//   req_wr         1 = write, 0 = read
//   req_addr       word address
//   req_wdata      write data
//   req_be         byte enables, bit i gates byte i
//   perr_inject    store inverted parity for the written bytes (parity build)
//   rsp_valid      one-cycle read-response pulse, RD_LAT edges after accept
//   rsp_rdata      read data, held between responses
//   rsp_perr       parity error on this response (0 without MEM_PARITY_EN)
//   init_done      array clear finished
module mem_sync_rw
  import mem_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [AWIDTH-1:0]   req_addr,
  input  logic [DWIDTH-1:0]   req_wdata,
  input  logic [DWIDTH/8-1:0] req_be,
  input  logic                perr_inject,
  output logic                rsp_valid,
  output logic [DWIDTH-1:0]   rsp_rdata,
  output logic                rsp_perr,
  output logic                init_done
);

  localparam int NBYTES = DWIDTH / 8;
  localparam int DEPTH  = 2 ** AWIDTH;
  // Out-of-range latencies are clamped to the supported pipeline depths.
  localparam int LAT    = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] clr_addr_q, clr_addr_d;

  // Array write port, shared by the clear sweep and bus writes.
  logic [NBYTES-1:0] mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              par_inv;
  logic              rd_fire;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_data;
  logic              rd_perr;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    mem_we     = '0;
    mem_waddr  = req_addr;
    mem_wdata  = req_wdata;
    par_inv    = 1'b0;
    rd_fire    = 1'b0;

    case (state_q)
      CLEAR: begin
        mem_we     = '1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + AWIDTH'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        if (req_valid) begin
          if (req_wr) begin
            mem_we  = req_be;
            par_inv = perr_inject;
          end else begin
            rd_fire = 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes it after every reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_we[i]) begin
        mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // A write on edge k is already in the array when a read samples on edge k+1,
  // so a plain combinational read gives read-after-write ordering.
  assign rd_data = mem_q[req_addr];

`ifdef MEM_PARITY_EN
  logic [NBYTES-1:0] par_q [DEPTH];
  logic [NBYTES-1:0] rd_par_calc;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NBYTES; i++) begin
      if (mem_we[i]) begin
        par_q[mem_waddr][i] <= byte_parity(mem_wdata[8*i +: 8]) ^ par_inv;
      end
    end
  end

  always_comb begin
    rd_par_calc = '0;
    for (int i = 0; i < NBYTES; i++) begin
      rd_par_calc[i] = byte_parity(rd_data[8*i +: 8]);
    end
  end

  assign rd_perr = |(rd_par_calc ^ par_q[req_addr]);
`else
  logic unused_par;
  assign unused_par = par_inv;
  assign rd_perr    = 1'b0;
`endif

  mem_rd_pipe #(
    .DWIDTH (DWIDTH),
    .RD_LAT (LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_fire),
    .in_data   (rd_data),
    .in_perr   (rd_perr),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata),
    .out_perr  (rsp_perr)
  );

  assign req_ready = (state_q == READY);
  assign init_done = (state_q == READY);

endmodule

// File: tb/tb_mem_sync_rw.sv
// tb/tb_mem_sync_rw.sv - scoreboard bench for mem_sync_rw (AWIDTH=5, DWIDTH=32, RD_LAT=3)
module tb_mem_sync_rw;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_be;
  logic          perr_inject;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_perr;
  logic          init_done;

  mem_sync_rw #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wr      (req_wr),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_be      (req_be),
    .perr_inject (perr_inject),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_perr    (rsp_perr),
    .init_done   (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    int            acc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [32];
  logic [3:0]    model_bad [32];
  logic [DW-1:0] last_rdata;
  int            cyc   = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.data);
        check("rsp_perr", {31'd0, rsp_perr}, {31'd0, e.perr});
        check("rsp_latency", 32'(cyc - e.acc + 1), 32'(LAT));
        last_rdata = e.data;
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = '0;
      model_bad[i] = '0;
    end
  endtask

  // All stimulus tasks start and end right after a falling edge.
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be, input logic inj);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d; req_be = be; perr_inject = inj;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        model_mem[a][8*i +: 8] = d[8*i +: 8];
        model_bad[a][i] = inj;
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    exp_t e;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    req_wdata = $urandom; req_be = 4'($urandom); perr_inject = 1'b0;
    e.data = model_mem[a];
`ifdef MEM_PARITY_EN
    e.perr = |model_bad[a];
`else
    e.perr = 1'b0;
`endif
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("drain_outstanding", 32'(sb.size()), 32'd0);
  endtask

  // Called right after rst_n is released at a falling edge; holds req_valid high.
  task automatic wait_init(input string tag);
    int lo;
    lo = 0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = '0;
    for (int i = 0; i < 100 && req_ready !== 1'b1; i++) begin
      lo++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check({tag, "_ready_low_cycles"}, 32'(lo), 32'd32);
    check({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; perr_inject = 1'b0; last_rdata = '0;
    model_clear();
    repeat (3) @(negedge clk);

    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_perr",  {31'd0, rsp_perr}, 32'd0);
    check("reset_init_done", {31'd0, init_done}, 32'd0);

    // Clear sweep, then every address reads zero.
    rst_n = 1'b1;
    wait_init("init1");
    for (int a = 0; a < 32; a++) rd(AW'(a));
    drain();

    // Byte-enable merge.
    wr(5'd3, 32'hDEADBEEF, 4'hF, 1'b0);
    wr(5'd3, 32'h11223344, 4'b0101, 1'b0);
    rd(5'd3);
    drain();
    check("be_merge_addr3", last_rdata, 32'hDE22BE44);

    // Back-to-back reads at full latency.
    wr(5'd0, 32'hA0, 4'hF, 1'b0);
    wr(5'd1, 32'hA1, 4'hF, 1'b0);
    wr(5'd2, 32'hA2, 4'hF, 1'b0);
    rd(5'd0); rd(5'd1); rd(5'd2);
    drain();

    // Read right after write, and be=0 no-op write.
    wr(5'd7, 32'h5, 4'hF, 1'b0);
    rd(5'd7);
    wr(5'd7, 32'hFFFFFFFF, 4'h0, 1'b0);
    rd(5'd7);
    drain();

    // Mixed pattern: random words with partial enables, interleaved reads.
    for (int k = 0; k < 6; k++) begin
      wr(AW'(10 + k), $urandom, 4'($urandom_range(0, 15)), 1'b0);
      rd(AW'(10 + k));
    end
    drain();

    // rsp_rdata holds while idle.
    repeat (3) @(negedge clk);
    check("rdata_hold", rsp_rdata, last_rdata);
    check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Parity inject and repair on byte 0.
    wr(5'd9, 32'hFF, 4'b0001, 1'b1);
    rd(5'd9);
    wr(5'd9, 32'hFF, 4'b0001, 1'b0);
    rd(5'd9);
    drain();

    // Reset with a read in flight: no response, array cleared again.
    wr(5'd7, 32'h5, 4'hF, 1'b0);
    rd(5'd7);
    rst_n = 1'b0;
    sb.delete();
    model_clear();
    repeat (4) @(negedge clk);
    check("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midreset_init_done", {31'd0, init_done}, 32'd0);
    rst_n = 1'b1;
    wait_init("init2");
    rd(5'd7);
    drain();
    check("after_reset_addr7", last_rdata, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
